noc_output_allocator: RTL and testbench



---
 rtl/noc_output_allocator.sv | 182 ++++++++++++++++++
 tb/tb_noc_output_allocator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_allocator.sv
// noc_output_allocator: wormhole allocator for one output port of the 5-port
// mesh router. Round-robin among headers, holds the grant until the tail,
// tracks downstream credits and force-releases a stalled packet via a
// watchdog.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req[4:0]        per-input request (0=L, 1=N, 2=E, 3=W, 4=S)
//   flit_id[14:0]   head flit type per input, port i at [3i+2:3i]
//                   (bit0 header, bit1 body, bit2 tail)
//   credit_ret      downstream freed one slot (pulse)
//   grant[4:0]      one-hot crossbar select, registered
//   xfer            flit moves this cycle (combinational)
//   credits         current credit count, registered
//   timeout_err     watchdog release strobe (combinational, in the release cycle)
//   pkt_count       completed packets
//
// Optional feature: define NOC_ALLOC_STATS_EN to build the pkt_count counter;
// otherwise pkt_count is tied to zero.
module noc_output_allocator #(
    parameter int unsigned CREDITS = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   req,
    input  logic [14:0]                  flit_id,
    input  logic                         credit_ret,
    output logic [4:0]                   grant,
    output logic                         xfer,
    output logic [$clog2(CREDITS):0]     credits,
    output logic                         timeout_err,
    output logic [15:0]                  pkt_count
);

    localparam int unsigned NPORTS = 5;
    localparam int unsigned CW     = $clog2(CREDITS) + 1;
    localparam int unsigned WD_W   = 12;

    typedef enum logic [0:0] {IDLE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      last_winner_q, last_winner_d;
    logic [4:0]      grant_q, grant_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic [WD_W-1:0] watchdog_q, watchdog_d;

    logic [4:0]      cand;
    logic            found;
    logic [2:0]      winner;
    logic [2:0]      flit_w;
    logic            req_w;
    logic            tail_xfer;
    logic            wd_fire;
    logic            unused_flit_bits;

    // Header candidates; body bits carry no meaning for arbitration.
    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            cand[i] = req[i] & flit_id[3*i];
        end
    end

    assign unused_flit_bits = ^{flit_id[1], flit_id[4], flit_id[7], flit_id[10], flit_id[13]};

    // Round-robin: first candidate after last_winner, modulo 5.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= NPORTS; k++) begin
            if (!found && cand[3'((32'(last_winner_q) + k) % NPORTS)]) begin
                found  = 1'b1;
                winner = 3'((32'(last_winner_q) + k) % NPORTS);
            end
        end
    end

    // Request and flit type of the current owner.
    always_comb begin
        flit_w = '0;
        req_w  = 1'b0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (owner_q == 3'(i)) begin
                flit_w = flit_id[3*i +: 3];
                req_w  = req[i];
            end
        end
    end

    assign xfer        = (state_q == HOLD) & req_w & (credits_q != '0);
    assign tail_xfer   = xfer & flit_w[2];
    assign wd_fire     = (state_q == HOLD) & ~xfer & (watchdog_q == WD_W'(TIMEOUT - 1));
    assign timeout_err = wd_fire;

    assign grant   = grant_q;
    assign credits = credits_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            last_winner_q <= 3'd4;
            grant_q       <= '0;
            credits_q     <= CW'(CREDITS);
            watchdog_q    <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_winner_q <= last_winner_d;
            grant_q       <= grant_d;
            credits_q     <= credits_d;
            watchdog_q    <= watchdog_d;
        end
    end

    // Next-state: allocation, wormhole hold, tail/watchdog release.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_winner_d = last_winner_q;
        grant_d       = grant_q;
        watchdog_d    = watchdog_q;
        unique case (state_q)
            IDLE: begin
                grant_d    = '0;
                watchdog_d = '0;
                if (found) begin
                    state_d         = HOLD;
                    owner_d         = winner;
                    grant_d[winner] = 1'b1;
                end
            end
            HOLD: begin
                if (tail_xfer || wd_fire) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    last_winner_d = owner_q;
                    watchdog_d    = '0;
                end else if (xfer) begin
                    watchdog_d = '0;
                end else begin
                    watchdog_d = watchdog_q + WD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Credits: simultaneous return and transfer cancel; return saturates.
    always_comb begin
        credits_d = credits_q;
        if (xfer && !credit_ret) begin
            credits_d = credits_q - CW'(1);
        end else if (!xfer && credit_ret && (credits_q != CW'(CREDITS))) begin
            credits_d = credits_q + CW'(1);
        end
    end

`ifdef NOC_ALLOC_STATS_EN
    logic [15:0] pkt_count_q;

    // Completed packets only; watchdog releases are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= '0;
        end else if (tail_xfer) begin
            pkt_count_q <= pkt_count_q + 16'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_noc_output_allocator.sv
// Directed bench for noc_output_allocator (CREDITS=4, TIMEOUT=64).
module tb_noc_output_allocator;

`ifdef NOC_ALLOC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req;
    logic [14:0] flit_id;
    logic        credit_ret;
    logic [4:0]  grant;
    logic        xfer;
    logic [2:0]  credits;
    logic        timeout_err;
    logic [15:0] pkt_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0] seq_a [4] = '{3'b001, 3'b010, 3'b010, 3'b100};
    logic [2:0] seq_b [4] = '{3'b001, 3'b010, 3'b010, 3'b010};

    noc_output_allocator #(.CREDITS(4), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .flit_id     (flit_id),
        .credit_ret  (credit_ret),
        .grant       (grant),
        .xfer        (xfer),
        .credits     (credits),
        .timeout_err (timeout_err),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] r, input logic [14:0] f, input logic cr);
        req        = r;
        flit_id    = f;
        credit_ret = cr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(5'b0, 15'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int         nx;
        int         idx;
        int         stalls;
        int         fired;
        logic       lastx;
        logic [2:0] f;

        // Reset state
        do_reset();
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_credits", 32'(credits), 32'd4);
        check("rst_xfer", 32'(xfer), 32'h0);
        check("rst_timeout", 32'(timeout_err), 32'h0);
        check("rst_pkt", 32'(pkt_count), 32'h0);

        // Single L packet: header, body, body, tail
        nx  = 0;
        idx = 0;
        for (int c = 1; c <= 7; c++) begin
            f = (idx < 4) ? seq_a[idx] : 3'b000;
            set_in((idx < 4) ? 5'b00001 : 5'b00000, {12'b0, f}, 1'b0);
            #1;
            if (c == 1) check("p1_grant_c1", 32'(grant), 32'h0);
            if (c == 2) begin
                check("p1_grant_c2", 32'(grant), 32'h1);
                check("p1_xfer_c2", 32'(xfer), 32'h1);
            end
            if (c == 6) begin
                check("p1_grant_after_tail", 32'(grant), 32'h0);
                check("p1_credits_empty", 32'(credits), 32'd0);
            end
            if (c == 7) check("p1_pkt", 32'(pkt_count), STATS ? 32'd1 : 32'd0);
            if (xfer) begin
                nx++;
                idx++;
            end
            next_cycle();
        end
        check("p1_xfer_count", 32'(nx), 32'd4);

        // Credit return with transfer, and saturation
        do_reset();
        set_in(5'b00001, 15'b001, 1'b0); next_cycle();
        set_in(5'b00001, 15'b001, 1'b0); #1;
        check("cr_hdr_xfer", 32'(xfer), 32'h1);
        next_cycle();
        set_in(5'b00001, 15'b010, 1'b0); next_cycle();
        set_in(5'b00001, 15'b010, 1'b1); #1;
        check("cr_at_two", 32'(credits), 32'd2);
        check("cr_both_xfer", 32'(xfer), 32'h1);
        next_cycle();
        set_in(5'b00000, 15'b010, 1'b0); #1;
        check("cr_both_same", 32'(credits), 32'd2);
        check("cr_hold_nreq", 32'(grant), 32'h1);
        next_cycle();
        set_in(5'b00000, 15'b0, 1'b1); next_cycle();
        set_in(5'b00000, 15'b0, 1'b1); next_cycle();
        set_in(5'b00000, 15'b0, 1'b1); #1;
        check("cr_full", 32'(credits), 32'd4);
        next_cycle();
        set_in(5'b00000, 15'b0, 1'b0); #1;
        check("cr_saturate", 32'(credits), 32'd4);
        next_cycle();
        set_in(5'b00001, 15'b100, 1'b0); #1;
        check("cr_tail_xfer", 32'(xfer), 32'h1);
        next_cycle();
        set_in(5'b00000, 15'b0, 1'b0); #1;
        check("cr_tail_release", 32'(grant), 32'h0);
        check("cr_after_tail", 32'(credits), 32'd3);
        next_cycle();

        // Reset in the middle of a packet
        do_reset();
        set_in(5'b00001, 15'b001, 1'b0); next_cycle();
        set_in(5'b00001, 15'b001, 1'b0); next_cycle();
        set_in(5'b00001, 15'b010, 1'b0); #1;
        check("mr_body_xfer", 32'(xfer), 32'h1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_in(5'b00001, 15'b010, 1'b0); #1;
        check("mr_grant", 32'(grant), 32'h0);
        check("mr_credits", 32'(credits), 32'd4);
        check("mr_xfer", 32'(xfer), 32'h0);
        next_cycle();
        set_in(5'b00001, 15'b010, 1'b0); #1;
        check("mr_body_ignored", 32'(grant), 32'h0);
        next_cycle();

        // Round-robin of single-flit packets on all five inputs
        do_reset();
        lastx = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_in(5'b11111, {5{3'b101}}, lastx);
            #1;
            check("rr_grant", 32'(grant), (k % 2 == 0) ? 32'h0 : (32'h1 << ((k / 2) % 5)));
            check("rr_xfer", 32'(xfer), 32'(k % 2));
            lastx = xfer;
            next_cycle();
        end

        // Stalled L packet (credits exhausted) released by the watchdog; N waits
        idx    = 0;
        stalls = 0;
        fired  = -1;
        for (int c = 0; c < 200; c++) begin
            f = seq_b[(idx < 4) ? idx : 3];
            set_in(5'b00011, {9'b0, 3'b001, f}, lastx);
            lastx = 1'b0;
            #1;
            if (grant == 5'b00001 && !xfer) stalls++;
            if (timeout_err) begin
                fired = stalls;
                next_cycle();
                break;
            end
            if (xfer) idx++;
            next_cycle();
        end
        check("wd_stall_cycles", 32'(fired), 32'd64);
        set_in(5'b00011, {9'b0, 3'b001, 3'b010}, 1'b0);
        #1;
        check("wd_idle", 32'(grant), 32'h0);
        check("wd_pulse_once", 32'(timeout_err), 32'h0);
        check("wd_pkt", 32'(pkt_count), STATS ? 32'd10 : 32'd0);
        next_cycle();
        set_in(5'b00011, {9'b0, 3'b001, 3'b010}, 1'b0);
        #1;
        check("wd_next_n", 32'(grant), 32'h2);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
